// File: rtl/hack_mem_responder.sv
// Hack data-memory responder: RAM, screen write port (optional read shadow, macro HACK_SCREEN_SHADOW_EN),
// keyboard FIFO and status. Reads are combinational; writes commit at posedge; key_ready low while the FIFO is full.
module hack_mem_responder #(
   parameter int KBD_DEPTH = 8,
   parameter int RAM_WORDS = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [0:14] ramAddr,
   input  logic [15:0] ramDout,
   input  logic        ramStore,
   output logic [15:0] ramDin,
   input  logic        key_valid,
   input  logic [15:0] key_code,
   output logic        key_ready,
   output logic        scr_we,
   output logic [12:0] scr_addr,
   output logic [15:0] scr_data
);
   localparam int PW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
   localparam int CW = $clog2(KBD_DEPTH + 1);
   localparam int AW = $clog2(RAM_WORDS);

   // ramAddr bit 0 is the MSB; repack to a conventional descending vector.
   logic [14:0] addr;
   assign addr = ramAddr;

   logic ram_sel, ram_in, scr_sel, kbd_sel, kst_sel;
   assign ram_sel = (addr[14] == 1'b0);
   assign ram_in  = ram_sel && (32'(addr) < RAM_WORDS);
   assign scr_sel = (addr[14:13] == 2'b10);
   assign kbd_sel = (addr == 15'h6000);
   assign kst_sel = (addr == 15'h6001);

   logic [15:0]   mem [RAM_WORDS];
   logic [15:0]   fifo_q [KBD_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          scr_we_q, scr_we_d;
   logic [12:0]   scr_addr_q, scr_addr_d;
   logic [15:0]   scr_data_q, scr_data_d;
   logic          push, drop, pop;

   assign key_ready = (count_q != CW'(KBD_DEPTH));
   assign scr_we    = scr_we_q;
   assign scr_addr  = scr_addr_q;
   assign scr_data  = scr_data_q;

   always_comb begin
      push       = key_valid && key_ready && (key_code != 16'h0000);
      drop       = key_valid && !key_ready && (key_code != 16'h0000);
      pop        = ramStore && kbd_sel && (count_q != '0);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      ovf_d      = ovf_q;
      if (ramStore && kst_sel) ovf_d = 1'b0;
      if (drop)                ovf_d = 1'b1;
      scr_we_d   = ramStore && scr_sel;
      scr_addr_d = scr_we_d ? addr[12:0] : scr_addr_q;
      scr_data_d = scr_we_d ? ramDout : scr_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         scr_we_q   <= 1'b0;
         scr_addr_q <= '0;
         scr_data_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         scr_we_q   <= scr_we_d;
         scr_addr_q <= scr_addr_d;
         scr_data_q <= scr_data_d;
      end
   end

   // Storage arrays are never reset; gating on rst_n drops writes at an edge during reset.
   always_ff @(posedge clk) begin
      if (rst_n && ramStore && ram_in) mem[addr[AW-1:0]] <= ramDout;
      if (rst_n && push)               fifo_q[wr_ptr_q]  <= key_code;
   end

`ifdef HACK_SCREEN_SHADOW_EN
   logic [15:0] shadow [8192];
   always_ff @(posedge clk) begin
      if (rst_n && ramStore && scr_sel) shadow[addr[12:0]] <= ramDout;
   end
`endif

   always_comb begin
      ramDin = 16'h0000;
      if (ram_in) begin
         ramDin = mem[addr[AW-1:0]];
      end else if (scr_sel) begin
`ifdef HACK_SCREEN_SHADOW_EN
         ramDin = shadow[addr[12:0]];
`else
         ramDin = 16'h0000;
`endif
      end else if (kbd_sel) begin
         ramDin = (count_q != '0) ? fifo_q[rd_ptr_q] : 16'h0000;
      end else if (kst_sel) begin
         ramDin = {ovf_q, 15'(count_q)};
      end
   end
endmodule

// File: tb/tb_hack_mem_responder.sv
// Randomized + directed bench for hack_mem_responder against a queue/array reference model.
module tb_hack_mem_responder;
   localparam int DEPTH = 8;
   localparam int RAMW  = 16384;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [14:0] ramAddr;
   logic [15:0] ramDout;
   logic        ramStore;
   logic [15:0] ramDin;
   logic        key_valid;
   logic [15:0] key_code;
   logic        key_ready;
   logic        scr_we;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;

   hack_mem_responder #(.KBD_DEPTH(DEPTH), .RAM_WORDS(RAMW)) dut (
      .clk(clk), .rst_n(rst_n), .ramAddr(ramAddr), .ramDout(ramDout), .ramStore(ramStore),
      .ramDin(ramDin), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
      .scr_we(scr_we), .scr_addr(scr_addr), .scr_data(scr_data)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [15:0] ram_m [int];
   logic [15:0] shadow_m [int];
   logic [15:0] q [$];
   logic        ovf_m;
   logic        m_we;
   logic [12:0] m_saddr;
   logic [15:0] m_sdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      ovf_m   = 1'b0;
      m_we    = 1'b0;
      m_saddr = '0;
      m_sdata = '0;
   endfunction

   function automatic void model_read(input logic [14:0] a, output logic ok, output logic [15:0] v);
      int ai = int'(a);
      ok = 1'b1;
      v  = 16'h0000;
      if (ai < 'h4000) begin
         if (ai < RAMW) begin
            if (ram_m.exists(ai)) v = ram_m[ai];
            else ok = 1'b0;
         end
      end else if (ai < 'h6000) begin
`ifdef HACK_SCREEN_SHADOW_EN
         if (shadow_m.exists(ai - 'h4000)) v = shadow_m[ai - 'h4000];
         else ok = 1'b0;
`endif
      end else if (ai == 'h6000) begin
         v = (q.size() > 0) ? q[0] : 16'h0000;
      end else if (ai == 'h6001) begin
         v = {ovf_m, 15'(q.size())};
      end
   endfunction

   function automatic void model_step(input logic [14:0] a, input logic [15:0] d, input logic st,
                                      input logic kv, input logic [15:0] kc);
      int  ai   = int'(a);
      bit  full = (q.size() == DEPTH);
      bit  pop  = st && ai == 'h6000 && q.size() > 0;
      if (pop) void'(q.pop_front());
      if (kv && kc != 0 && !full) q.push_back(kc);
      if (st && ai == 'h6001) ovf_m = 1'b0;
      if (kv && kc != 0 && full) ovf_m = 1'b1;
      if (st && ai < RAMW) ram_m[ai] = d;
      m_we = st && ai >= 'h4000 && ai < 'h6000;
      if (m_we) begin
         m_saddr = 13'(ai - 'h4000);
         m_sdata = d;
         shadow_m[ai - 'h4000] = d;
      end
   endfunction

   // One clock: drive at negedge, check combinational read, clock it, check screen port.
   task automatic cyc(input logic [14:0] a, input logic [15:0] d, input logic st,
                      input logic kv, input logic [15:0] kc);
      logic        ok;
      logic [15:0] ev;
      ramAddr = a; ramDout = d; ramStore = st; key_valid = kv; key_code = kc;
      #1;
      model_read(a, ok, ev);
      if (ok) chk("ramDin", ramDin, ev);
      chk("key_ready", key_ready, q.size() != DEPTH);
      @(posedge clk);
      model_step(a, d, st, kv, kc);
      #1;
      chk("scr_we", scr_we, m_we);
      if (m_we) begin
         chk("scr_addr", scr_addr, m_saddr);
         chk("scr_data", scr_data, m_sdata);
      end
      @(negedge clk);
   endtask

   task automatic look(input string tag, input logic [14:0] a, input logic [15:0] v);
      ramAddr = a; ramStore = 1'b0; key_valid = 1'b0;
      #1;
      chk(tag, ramDin, v);
   endtask

   initial begin
      logic [14:0] a;
      rst_n = 1'b0; ramAddr = '0; ramDout = '0; ramStore = 1'b0; key_valid = 1'b0; key_code = '0;
      model_reset();
      #1;
      chk("rst_key_ready", key_ready, 1);
      chk("rst_scr_we", scr_we, 0);
      chk("rst_scr_addr", scr_addr, 0);
      chk("rst_scr_data", scr_data, 0);
      look("rst_kstat", 15'h6001, 16'h0000);
      look("rst_kbd", 15'h6000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // RAM read-back and top RAM word
      cyc(15'd5, 16'h1234, 1, 0, 0);
      look("ram5", 15'd5, 16'h1234);
      cyc(15'h3FFF, 16'hBEEF, 1, 0, 0);
      look("ram3fff", 15'h3FFF, 16'hBEEF);
      chk("ram_no_scr", scr_we, 0);

      // Screen path
      cyc(15'h4001, 16'hAAAA, 1, 0, 0);
      chk("scr_pulse_addr", scr_addr, 1);
      cyc(15'h4001, 16'h0000, 0, 0, 0);
      chk("scr_pulse_end", scr_we, 0);
`ifdef HACK_SCREEN_SHADOW_EN
      look("scr_read", 15'h4001, 16'hAAAA);
`else
      look("scr_read", 15'h4001, 16'h0000);
`endif
      cyc(15'h4100, 16'h0101, 1, 0, 0);
      cyc(15'h5FFF, 16'h0202, 1, 0, 0);
      look("unmapped", 15'h7123, 16'h0000);

      // FIFO order and pops
      cyc(15'h0, 0, 0, 1, 16'h41);
      cyc(15'h0, 0, 0, 1, 16'h42);
      look("kbd_head", 15'h6000, 16'h41);
      look("kstat2", 15'h6001, 16'h0002);
      cyc(15'h6000, 16'hFFFF, 1, 0, 0);
      look("kbd_next", 15'h6000, 16'h42);
      cyc(15'h6000, 16'h0, 1, 0, 0);
      look("kbd_empty", 15'h6000, 16'h0000);
      look("kstat0", 15'h6001, 16'h0000);
      cyc(15'h6000, 16'h0, 1, 0, 0);
      look("kbd_extra_pop", 15'h6000, 16'h0000);

      // Overflow
      for (int i = 1; i <= 9; i++) cyc(15'h0, 0, 0, 1, 16'(16'h60 + i));
      chk("full_ready", key_ready, 0);
      look("kstat_ovf", 15'h6001, 16'h8008);
      cyc(15'h6001, 16'h1234, 1, 0, 0);
      look("kstat_clr", 15'h6001, 16'h0008);
      cyc(15'h0, 0, 0, 1, 16'h0000);
      look("zero_push", 15'h6001, 16'h0008);
      cyc(15'h6000, 0, 1, 1, 16'h77);
      look("full_pushpop", 15'h6001, 16'h8007);
      cyc(15'h0, 0, 0, 1, 16'h78);
      cyc(15'h6001, 0, 1, 1, 16'h79);
      look("set_wins", 15'h6001, 16'h8008);

      // Simultaneous push/pop
      for (int i = 0; i < DEPTH; i++) cyc(15'h6000, 0, 1, 0, 0);
      cyc(15'h6001, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(15'h0, 0, 0, 1, 16'(16'hA0 + i));
      cyc(15'h6000, 0, 1, 1, 16'hA3);
      look("pp_count", 15'h6001, 16'h0003);
      look("pp_head", 15'h6000, 16'h00A1);
      for (int i = 0; i < 3; i++) cyc(15'h6000, 0, 1, 0, 0);
      cyc(15'h6000, 0, 1, 1, 16'h55);
      look("empty_pp", 15'h6001, 16'h0001);
      look("empty_pp_head", 15'h6000, 16'h0055);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 5))
            0:       a = 15'($urandom_range(8, 23));
            1:       a = 15'($urandom_range('h3FF0, 'h3FFF));
            2:       a = 15'($urandom_range('h4000, 'h5FFF));
            3:       a = 15'h6000;
            4:       a = 15'h6001;
            default: a = 15'($urandom_range('h6002, 'h7FFF));
         endcase
         cyc(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 'hFFFF)));
      end

      // Async reset with count=5, overflow=1 and a screen pulse pending
      while (q.size() > 0) cyc(15'h6000, 0, 1, 0, 0);
      for (int i = 0; i < DEPTH + 1; i++) cyc(15'h0, 0, 0, 1, 16'(16'hC0 + i));
      for (int i = 0; i < 3; i++) cyc(15'h6000, 0, 1, 0, 0);
      look("pre_rst_kstat", 15'h6001, 16'h8005);
      cyc(15'h4002, 16'h5555, 1, 0, 0);
      chk("pre_rst_scr_we", scr_we, 1);
      rst_n = 1'b0;
      model_reset();
      look("arst_kstat", 15'h6001, 16'h0000);
      chk("arst_scr_we", scr_we, 0);
      chk("arst_key_ready", key_ready, 1);
      look("arst_kbd", 15'h6000, 16'h0000);
      look("arst_ram5", 15'd5, 16'h1234);
      rst_n = 1'b1;
      cyc(15'h0, 0, 0, 1, 16'hE1);
      look("post_rst_kbd", 15'h6000, 16'h00E1);
      cyc(15'd5, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
